// File: rtl/shifter_pkg.sv
// Shared types and constants for the barrel shifter datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Build option: define SHIFTER_ROTATE_EN to enable rotate-right on opcode 2'b11.
package shifter_pkg;

  // Default operand width; must be a power of two, at least 2.
  localparam int DEFAULT_DATA_W = 32;

  // Shift opcode encoding as seen on the shiftop port.
  typedef enum logic [1:0] {
    SHIFT_SRL = 2'b00,
    SHIFT_SRA = 2'b01,
    SHIFT_SLL = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational log-barrel shifter: SRL, SRA, SLL and optional ROR.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
// Build option: SHIFTER_ROTATE_EN adds rotate-right; otherwise opcode 2'b11 yields zero.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_in,
  input  shift_op_t         op,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] data_out
);

  logic              is_sll;
  logic              fill_bit;
  logic [DATA_W-1:0] data_rev;
  logic [DATA_W-1:0] net_rev;
  logic [DATA_W-1:0] stage [AMT_W+1];

  assign is_sll   = (op == SHIFT_SLL);
  // Only SRA replicates the sign; every other shifting op zero-fills.
  assign fill_bit = (op == SHIFT_SRA) ? data_in[DATA_W-1] : 1'b0;

  // Left shift reuses the right-shift network by mirroring the word on both sides.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign data_rev[i] = data_in[DATA_W-1-i];
    assign net_rev[i]  = stage[AMT_W][DATA_W-1-i];
  end

  assign stage[0] = is_sll ? data_rev : data_in;

`ifdef SHIFTER_ROTATE_EN
  logic is_ror;
  assign is_ror = (op == SHIFT_ROR);
`endif

  // Stage k shifts right by 2^k when amt[k] is set.
  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [S-1:0] hi_bits;
`ifdef SHIFTER_ROTATE_EN
    // Rotate feeds the bits falling off the bottom back in at the top.
    assign hi_bits = is_ror ? stage[k][S-1:0] : {S{fill_bit}};
`else
    assign hi_bits = {S{fill_bit}};
`endif
    assign stage[k+1] = amt[k] ? {hi_bits, stage[k][DATA_W-1:S]} : stage[k];
  end

  // Select final orientation; opcode 2'b11 is zero unless rotate is built in.
  always_comb begin
    data_out = stage[AMT_W];
    if (is_sll) begin
      data_out = net_rev;
    end
`ifndef SHIFTER_ROTATE_EN
    if (op == SHIFT_ROR) begin
      data_out = '0;
    end
`endif
  end

endmodule

// File: rtl/barrel_shifter.sv
// Registered 32-bit barrel shifter for ALU shift instructions.
// Latency: 1 cycle from in_valid to out_valid/result.
// Backpressure: none; accepts one operation every cycle, never stalls.
// Build option: SHIFTER_ROTATE_EN enables rotate-right on shiftop 2'b11.
module barrel_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        shiftop,
  input  logic [AMT_W-1:0]  shiftamt,
  output logic              out_valid,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] core_out;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] result_q;
  logic              out_valid_d;
  logic              out_valid_q;

  shifter_core #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_core (
    .data_in  (in),
    .op       (shift_op_t'(shiftop)),
    .amt      (shiftamt),
    .data_out (core_out)
  );

  // Capture a new result only on valid input; otherwise hold the last one.
  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    if (in_valid) begin
      result_d = core_out;
    end
  end

  // Output register with synchronous reset that discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter with a queue-based scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Build option: SHIFTER_ROTATE_EN selects the expected value for opcode 2'b11.
module tb_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] din;
  logic [1:0]  shiftop;
  logic [4:0]  shiftamt;
  logic        out_valid;
  logic [31:0] result;

  logic [31:0] sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  barrel_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (din),
    .shiftop   (shiftop),
    .shiftamt  (shiftamt),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Reference model built from language shift operators.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] op,
                                        input logic [4:0] a);
    logic [5:0] back;
    back = 6'd32 - {1'b0, a};
    case (op)
      2'b00:   return d >> a;
      2'b01:   return 32'($signed(d) >>> a);
      2'b10:   return d << a;
`ifdef SHIFTER_ROTATE_EN
      default: return (d >> a) | (d << back);
`else
      default: return (back == 6'd0) ? 32'h0 : 32'h0;
`endif
    endcase
  endfunction

  function automatic logic [31:0] pop_exp();
    if (sb.size() == 0) return 32'hDEAD_BEEF;
    return sb.pop_front();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] op,
                       input logic [4:0] a);
    in_valid = v;
    din      = d;
    shiftop  = op;
    shiftamt = a;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 2'b00, 5'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || result !== 32'h0)
        $display("FAIL reset cyc%0d: got vld=%b res=%h, want vld=0 res=00000000", c, out_valid, result);
      else n_pass++;
    end
    rst = 1'b0;
    drive(1'b1, 32'h1234_5678, 2'b10, 5'd4);
    sb.push_back(32'h2345_6780);
    step();
    exp = pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || result !== exp)
      $display("FAIL first_after_reset: got vld=%b res=%h, want vld=1 res=%h", out_valid, result, exp);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int op = 0; op < 3; op++) begin
        drive(1'b1, 32'h0000_00F0, 2'(op), 5'(a));
        sb.push_back(model(32'h0000_00F0, 2'(op), 5'(a)));
        step();
        exp = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || result !== exp)
          $display("FAIL sweep op=%0d amt=%0d: got vld=%b res=%h, want vld=1 res=%h",
                   op, a, out_valid, result, exp);
        else n_pass++;
      end
    end
    // Spot values stated directly rather than through the model.
    drive(1'b1, 32'h0000_00F0, 2'b00, 5'd4);
    sb.push_back(32'h0000_000F);
    step();
    exp = pop_exp();
    n_checks++;
    if (result !== exp) $display("FAIL sweep_srl4: got %h, want %h", result, exp);
    else n_pass++;
    drive(1'b1, 32'h0000_00F0, 2'b10, 5'd4);
    sb.push_back(32'h0000_0F00);
    step();
    exp = pop_exp();
    n_checks++;
    if (result !== exp) $display("FAIL sweep_sll4: got %h, want %h", result, exp);
    else n_pass++;
  endtask

  task automatic test_sign_fill();
    logic [1:0]  ops  [6] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10};
    logic [4:0]  amts [6] = '{5'd4, 5'd4, 5'd4, 5'd31, 5'd31, 5'd31};
    logic [31:0] exps [6] = '{32'h0800_0001, 32'hF800_0001, 32'h0000_0100,
                              32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h8000_0010, ops[i], amts[i]);
      sb.push_back(exps[i]);
      step();
      exp = pop_exp();
      n_checks++;
      if (out_valid !== 1'b1 || result !== exp)
        $display("FAIL sign_fill op=%0d amt=%0d: got vld=%b res=%h, want vld=1 res=%h",
                 ops[i], amts[i], out_valid, result, exp);
      else n_pass++;
    end
    // Max-distance SLL brings bit 0 to bit 31.
    drive(1'b1, 32'h0000_0001, 2'b10, 5'd31);
    sb.push_back(32'h8000_0000);
    step();
    exp = pop_exp();
    n_checks++;
    if (result !== exp) $display("FAIL sll31_bit0: got %h, want %h", result, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d    [3] = '{32'hA5A5_0F0F, 32'h8765_4321, 32'h0000_FFFF};
    logic [1:0]  ops  [3] = '{2'b00, 2'b01, 2'b10};
    logic [4:0]  amts [3] = '{5'd8, 5'd12, 5'd16};
    logic [31:0] exp;
    logic [31:0] last = 32'h0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, d[i], ops[i], amts[i]);
      sb.push_back(model(d[i], ops[i], amts[i]));
      step();
      exp  = pop_exp();
      last = exp;
      n_checks++;
      if (out_valid !== 1'b1 || result !== exp)
        $display("FAIL b2b op%0d: got vld=%b res=%h, want vld=1 res=%h", i, out_valid, result, exp);
      else n_pass++;
    end
    // Gap: inputs change but are not qualified; result must hold.
    for (int g = 0; g < 2; g++) begin
      drive(1'b0, 32'h1357_9BDF + 32'(g), 2'(g), 5'(3 + g));
      step();
      n_checks++;
      if (out_valid !== 1'b0 || result !== last)
        $display("FAIL gap cyc%0d: got vld=%b res=%h, want vld=0 res=%h", g, out_valid, result, last);
      else n_pass++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_op11();
    logic [31:0] exp;
    drive(1'b1, 32'h0000_0003, 2'b11, 5'd1);
`ifdef SHIFTER_ROTATE_EN
    sb.push_back(32'h8000_0001);
`else
    sb.push_back(32'h0000_0000);
`endif
    step();
    exp = pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || result !== exp)
      $display("FAIL op11: got vld=%b res=%h, want vld=1 res=%h", out_valid, result, exp);
    else n_pass++;
    drive(1'b1, 32'h0000_0001, 2'b11, 5'd1);
    sb.push_back(model(32'h0000_0001, 2'b11, 5'd1));
    step();
    exp = pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || result !== exp)
      $display("FAIL op11_ror1: got vld=%b res=%h, want vld=1 res=%h", out_valid, result, exp);
    else n_pass++;
    drive(1'b1, 32'hCAFE_BABE, 2'b11, 5'd0);
`ifdef SHIFTER_ROTATE_EN
    sb.push_back(32'hCAFE_BABE);
`else
    sb.push_back(32'h0000_0000);
`endif
    step();
    exp = pop_exp();
    n_checks++;
    if (result !== exp) $display("FAIL op11_amt0: got %h, want %h", result, exp);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp;
    drive(1'b1, 32'hF000_000F, 2'b00, 5'd2);
    sb.push_back(32'h3C00_0003);
    step();
    exp = pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || result !== exp)
      $display("FAIL midrst_pre: got vld=%b res=%h, want vld=1 res=%h", out_valid, result, exp);
    else n_pass++;
    // Reset arrives together with another valid op, which must be dropped.
    rst = 1'b1;
    drive(1'b1, 32'h1111_1111, 2'b10, 5'd1);
    step();
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'h0)
      $display("FAIL midrst_edge: got vld=%b res=%h, want vld=0 res=00000000", out_valid, result);
    else n_pass++;
    rst = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 5'd0);
    step();
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'h0)
      $display("FAIL midrst_stale: got vld=%b res=%h, want vld=0 res=00000000", out_valid, result);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 5'd0);
    @(posedge clk);
    #1;
    test_reset();
    test_sweep();
    test_sign_fill();
    test_back_to_back();
    test_op11();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
